evict_ctrl: RTL
===============

EVICT_CTRL -- requirements
Module: evict_ctrl

Interface
REQ-001 SHALL have parameter SET_W, default 6: set index width.
REQ-002 SHALL have parameter WAY_NUM, default 4: associativity, legal values 2, 4 or 8.
REQ-003 SHALL have parameter WAY_IDX_W, default 2: way index width, equal to log2(WAY_NUM).
REQ-004 SHALL have parameter TAG_W, default 20: tag width.
REQ-005 SHALL have parameter STARVE_MAX, default 4: maximum number of consecutive cycles a refill touch may be deferred.
REQ-006 SHALL have port clk  in  1: the single clock.
REQ-007 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-008 SHALL have ports miss_valid in 1, miss_ready out 1, miss_set in SET_W, miss_tag in TAG_W: the miss request.
REQ-009 SHALL have port rep_set  out  SET_W: set presented to the replacer and to the meta read.
REQ-010 SHALL have port rep_way  in  WAY_IDX_W: victim way, valid one cycle after rep_set is driven.
REQ-011 SHALL have port way_dirty  in  WAY_NUM: dirty bits of rep_set, valid one cycle after rep_set is driven.
REQ-012 SHALL have ports wb_valid out 1, wb_ready in 1, wb_set out SET_W, wb_way out WAY_IDX_W, wb_done in 1: the writeback request.
REQ-013 SHALL have ports fill_valid out 1, fill_ready in 1, fill_set out SET_W, fill_way out WAY_IDX_W, fill_tag out TAG_W, fill_done in 1: the refill request.
REQ-014 SHALL have ports hit_touch_valid in 1, hit_touch_set in SET_W, hit_touch_way in WAY_IDX_W: touches from the hit path.
REQ-015 SHALL have ports rep_access_valid out 1, rep_access_set out SET_W, rep_access_way out WAY_IDX_W: the arbitrated PLRU touch.
REQ-016 SHALL have ports busy out 1 and done out 1 (one-cycle pulse).

Function
REQ-017 SHALL implement states IDLE, SEL, DECIDE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, TOUCH.
REQ-018 SHALL assert miss_ready only in IDLE; on handshake, latch set/tag, drive rep_set=latched set from the next cycle and enter SEL.
REQ-019 SHALL pass SEL in exactly 1 cycle, then in DECIDE latch rep_way as victim and way_dirty[rep_way] as dirty.
REQ-020 SHALL go from DECIDE to WB_REQ if dirty, else to FILL_REQ.
REQ-021 SHALL hold wb_valid with stable wb_set/wb_way in WB_REQ until wb_ready, then enter WB_WAIT.
REQ-022 SHALL leave WB_WAIT for FILL_REQ on wb_done; wb_done outside WB_WAIT SHALL be ignored.
REQ-023 SHALL handle FILL_REQ/FILL_WAIT identically with fill_*, entering TOUCH on fill_done.
REQ-024 SHALL, when hit_touch_valid is asserted, forward it to rep_access_* combinationally, except as in REQ-026.
REQ-025 SHALL in TOUCH, when hit_touch_valid is low, drive rep_access_*={1, latched set, victim}, pulse done, and return to IDLE.
REQ-026 SHALL count deferred TOUCH cycles; when the count reaches STARVE_MAX, the refill touch wins, the hit touch in that cycle is dropped, and the counter clears on leaving TOUCH.
REQ-027 SHALL drive busy=1 in every state except IDLE.
REQ-028 SHALL accept a new miss in the cycle after done; minimum miss-to-done for a clean victim with ready/done tied high is 5 cycles.

Reset
REQ-029 SHALL on rst enter IDLE and clear the counter and latched fields, giving outputs miss_ready=1, wb_valid=0, fill_valid=0, done=0, busy=0, and rep_set, wb_*, fill_* data=0.
REQ-030 SHALL abandon an in-flight writeback or refill if reset arrives mid-operation, with no touch issued.
REQ-031 SHALL forward rep_access_* from hit_touch_* during reset, because the path is combinational.

Structure
REQ-032 SHALL place the state enum and STARVE_MAX default in mpc_types.
REQ-033 SHALL instantiate one sub-module, touch_arb, holding the arbitration mux and starvation counter.

Verification
REQ-034 Clean miss, set 5, rep_way=2, way_dirty=0, ready/done high -> fill_way=2 with no wb_valid, touch {5,2}, done at cycle 5.
REQ-035 Dirty miss, rep_way=3, way_dirty=4'b1000 -> wb {set,3} precedes fill {set,3}, and fill_valid stays low until wb_done.
REQ-036 hit_touch_valid held high throughout TOUCH -> hit touches pass for 4 cycles, refill touch issued in cycle 5, that hit dropped.
REQ-037 wb_ready low for 10 cycles -> wb_valid/set/way stable for the whole wait, miss_ready=0 throughout.
REQ-038 rst asserted in FILL_WAIT -> IDLE next edge, no touch, no done, miss_ready=1.
REQ-039 WAY_NUM=8 build, rep_way=7 dirty -> wb_way=7, fill_way=7, touch way 7.

Source files
------------

// File: rtl/evict_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mpc_types (package)
//  Description : Shared types for the eviction controller: the controller
//                state enumeration and the default refill-touch starvation
//                limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mpc_types;

    // Default maximum number of consecutive cycles a refill touch may be
    // deferred behind hit-path touches.
    localparam int unsigned c_starve_max_def = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEL       = 3'd1,
        ST_DECIDE    = 3'd2,
        ST_WB_REQ    = 3'd3,
        ST_WB_WAIT   = 3'd4,
        ST_FILL_REQ  = 3'd5,
        ST_FILL_WAIT = 3'd6,
        ST_TOUCH     = 3'd7
    } state_e;

endpackage : mpc_types
`default_nettype wire

// File: rtl/evict_ctrl_touch_arb.sv
`default_nettype none
// ============================================================================
//  Module      : touch_arb
//  Description : Arbitrates the single PLRU touch port between hit-path
//                touches and the refill touch of the eviction controller.
//                Hit touches win and are forwarded combinationally; the
//                refill touch waits, but only for STARVE_MAX consecutive
//                cycles, after which it wins and that cycle's hit is dropped.
//  Ports       : i_in_touch          - controller is in its TOUCH state
//                i_hit_touch_*       - touch request from the hit path
//                i_refill_set/way    - set/way of the refill touch
//                o_rep_access_*      - arbitrated touch to the replacer
//                o_refill_grant      - refill touch issued this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module touch_arb #(
    parameter int SET_W      = 6,
    parameter int WAY_IDX_W  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_in_touch,
    input  logic                 i_hit_touch_valid,
    input  logic [SET_W-1:0]     i_hit_touch_set,
    input  logic [WAY_IDX_W-1:0] i_hit_touch_way,
    input  logic [SET_W-1:0]     i_refill_set,
    input  logic [WAY_IDX_W-1:0] i_refill_way,
    output logic                 o_rep_access_valid,
    output logic [SET_W-1:0]     o_rep_access_set,
    output logic [WAY_IDX_W-1:0] o_rep_access_way,
    output logic                 o_refill_grant
);

    localparam int                 c_cnt_w = $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_MAX);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [c_cnt_w-1:0] w_cnt_d;
    logic               w_starved;
    logic               w_hit_wins;

    always_comb begin
        w_starved          = (r_cnt_q >= c_limit);
        // Outside TOUCH the hit path always owns the port.
        w_hit_wins         = i_hit_touch_valid && !(i_in_touch && w_starved);
        o_rep_access_valid = i_hit_touch_valid || i_in_touch;
        o_rep_access_set   = w_hit_wins ? i_hit_touch_set : i_refill_set;
        o_rep_access_way   = w_hit_wins ? i_hit_touch_way : i_refill_way;
        o_refill_grant     = i_in_touch && !w_hit_wins;

        // Counting only happens while a refill touch is actually waiting;
        // the grant cycle is the last TOUCH cycle, so it clears here too.
        w_cnt_d = r_cnt_q;
        if (!i_in_touch || o_refill_grant) begin
            w_cnt_d = '0;
        end else begin
            w_cnt_d = r_cnt_q + c_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule : touch_arb
`default_nettype wire

// File: rtl/evict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : evict_ctrl
//  Description : Cache miss eviction controller. Accepts a miss, queries the
//                replacer for a victim, writes the victim back if dirty,
//                requests the refill, then issues the PLRU touch for the
//                refilled way and pulses done.
//  Ports       : miss_*        - miss request (valid/ready)
//                rep_set       - set driven to replacer and meta read
//                rep_way       - victim way, one cycle after rep_set
//                way_dirty     - dirty bits of rep_set, one cycle after
//                wb_*          - writeback request / completion
//                fill_*        - refill request / completion
//                hit_touch_*   - PLRU touches from the hit path
//                rep_access_*  - arbitrated PLRU touch
//                busy, done    - status; done is a one-cycle pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module evict_ctrl
    import mpc_types::*;
#(
    parameter int SET_W      = 6,
    parameter int WAY_NUM    = 4,
    parameter int WAY_IDX_W  = 2,
    parameter int TAG_W      = 20,
    parameter int STARVE_MAX = c_starve_max_def
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [SET_W-1:0]     miss_set,
    input  logic [TAG_W-1:0]     miss_tag,
    output logic [SET_W-1:0]     rep_set,
    input  logic [WAY_IDX_W-1:0] rep_way,
    input  logic [WAY_NUM-1:0]   way_dirty,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [SET_W-1:0]     wb_set,
    output logic [WAY_IDX_W-1:0] wb_way,
    input  logic                 wb_done,
    output logic                 fill_valid,
    input  logic                 fill_ready,
    output logic [SET_W-1:0]     fill_set,
    output logic [WAY_IDX_W-1:0] fill_way,
    output logic [TAG_W-1:0]     fill_tag,
    input  logic                 fill_done,
    input  logic                 hit_touch_valid,
    input  logic [SET_W-1:0]     hit_touch_set,
    input  logic [WAY_IDX_W-1:0] hit_touch_way,
    output logic                 rep_access_valid,
    output logic [SET_W-1:0]     rep_access_set,
    output logic [WAY_IDX_W-1:0] rep_access_way,
    output logic                 busy,
    output logic                 done
);

    state_e                 r_state_q;
    state_e                 w_state_d;
    logic [SET_W-1:0]       r_set_q;
    logic [SET_W-1:0]       w_set_d;
    logic [TAG_W-1:0]       r_tag_q;
    logic [TAG_W-1:0]       w_tag_d;
    logic [WAY_IDX_W-1:0]   r_victim_q;
    logic [WAY_IDX_W-1:0]   w_victim_d;
    logic                   w_victim_dirty;
    logic                   w_in_touch;
    logic                   w_refill_grant;

    // The dirty bit is consumed in the DECIDE cycle itself; the choice of
    // WB_REQ versus FILL_REQ is what carries it forward.
    assign w_victim_dirty = way_dirty[rep_way];

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE:      if (miss_valid)     w_state_d = ST_SEL;
            ST_SEL:                           w_state_d = ST_DECIDE;
            ST_DECIDE:    w_state_d = w_victim_dirty ? ST_WB_REQ : ST_FILL_REQ;
            ST_WB_REQ:    if (wb_ready)       w_state_d = ST_WB_WAIT;
            ST_WB_WAIT:   if (wb_done)        w_state_d = ST_FILL_REQ;
            ST_FILL_REQ:  if (fill_ready)     w_state_d = ST_FILL_WAIT;
            ST_FILL_WAIT: if (fill_done)      w_state_d = ST_TOUCH;
            ST_TOUCH:     if (w_refill_grant) w_state_d = ST_IDLE;
            default:                          w_state_d = ST_IDLE;
        endcase
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        miss_ready = (r_state_q == ST_IDLE);
        busy       = (r_state_q != ST_IDLE);
        wb_valid   = (r_state_q == ST_WB_REQ);
        fill_valid = (r_state_q == ST_FILL_REQ);
        w_in_touch = (r_state_q == ST_TOUCH);
        done       = w_refill_grant;
    end

    // -------------------------------------------------------- latched fields
    always_comb begin
        w_set_d    = r_set_q;
        w_tag_d    = r_tag_q;
        w_victim_d = r_victim_q;
        if ((r_state_q == ST_IDLE) && miss_valid) begin
            w_set_d = miss_set;
            w_tag_d = miss_tag;
        end
        if (r_state_q == ST_DECIDE) begin
            w_victim_d = rep_way;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_set_q    <= '0;
            r_tag_q    <= '0;
            r_victim_q <= '0;
        end else begin
            r_set_q    <= w_set_d;
            r_tag_q    <= w_tag_d;
            r_victim_q <= w_victim_d;
        end
    end

    // Request payloads come straight from the latched fields, so they stay
    // stable for as long as a request is held.
    assign rep_set  = r_set_q;
    assign wb_set   = r_set_q;
    assign wb_way   = r_victim_q;
    assign fill_set = r_set_q;
    assign fill_way = r_victim_q;
    assign fill_tag = r_tag_q;

    touch_arb #(
        .SET_W      (SET_W),
        .WAY_IDX_W  (WAY_IDX_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_touch_arb (
        .clk                (clk),
        .rst                (rst),
        .i_in_touch         (w_in_touch),
        .i_hit_touch_valid  (hit_touch_valid),
        .i_hit_touch_set    (hit_touch_set),
        .i_hit_touch_way    (hit_touch_way),
        .i_refill_set       (r_set_q),
        .i_refill_way       (r_victim_q),
        .o_rep_access_valid (rep_access_valid),
        .o_rep_access_set   (rep_access_set),
        .o_rep_access_way   (rep_access_way),
        .o_refill_grant     (w_refill_grant)
    );

endmodule : evict_ctrl
`default_nettype wire
